// File: rtl/mem_dma_engine.sv
// Byte-granular memory-to-memory copy engine driving a single RAM port.
// Each chunk of 4/2/1 bytes is gathered by single-byte reads, then written back with one big-endian write.
module mem_dma_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_bus_col
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] src_reg, src_next;
    logic [31:0] dst_reg, dst_next;
    logic [15:0] remain_reg, remain_next;
    logic [15:0] offset_reg, offset_next;
    logic [1:0]  k_reg, k_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic [7:0]  b_reg [3];
    logic [2:0]  cap_en;
    logic [2:0]  chunk;
    logic        last_read;
    logic        unused_rdata_hi;

    assign unused_rdata_hi = ^mem_rdata[31:8];

    // Chunk size is a pure function of the remaining count, which only changes at chunk boundaries.
    always_comb begin
        chunk = 3'd1;
        if (remain_reg >= 16'd4)
            chunk = 3'd4;
        else if (remain_reg >= 16'd2)
            chunk = 3'd2;
    end

    assign last_read = ({1'b0, k_reg} == (chunk - 3'd1));

    // Read cycle k returns byte k-1 of the chunk on mem_rdata.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cap
            assign cap_en[gi] = (state_reg == READ) && (k_reg == 2'(gi + 1));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) b_reg[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 3; i++)
                if (cap_en[i]) b_reg[i] <= mem_rdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            src_reg    <= 32'h0;
            dst_reg    <= 32'h0;
            remain_reg <= 16'h0;
            offset_reg <= 16'h0;
            k_reg      <= 2'd0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            src_reg    <= src_next;
            dst_reg    <= dst_next;
            remain_reg <= remain_next;
            offset_reg <= offset_next;
            k_reg      <= k_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign err  = err_reg;

    always_comb begin
        state_next  = state_reg;
        src_next    = src_reg;
        dst_next    = dst_reg;
        remain_next = remain_reg;
        offset_next = offset_reg;
        k_next      = k_reg;
        done_next   = 1'b0;
        err_next    = err_reg;
        mem_we      = 4'b0000;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;

        if (mem_bus_col && (busy || done_reg))
            err_next = 1'b1;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    err_next = 1'b0;
                    if (len == 16'h0) begin
                        done_next = 1'b1;
                    end else begin
                        src_next    = src_addr;
                        dst_next    = dst_addr;
                        remain_next = len;
                        offset_next = 16'h0;
                        k_next      = 2'd0;
                        state_next  = READ;
                    end
                end
            end
            READ: begin
                mem_addr = src_reg + {16'h0, offset_reg} + {30'h0, k_reg};
                if (last_read) begin
                    k_next     = 2'd0;
                    state_next = WRITE;
                end else begin
                    k_next = k_reg + 2'd1;
                end
            end
            WRITE: begin
                mem_addr = dst_reg + {16'h0, offset_reg};
                // The final byte of the chunk is still on mem_rdata, so it is forwarded directly.
                case (chunk)
                    3'd4: begin
                        mem_we    = 4'b1111;
                        mem_wdata = {b_reg[0], b_reg[1], b_reg[2], mem_rdata[7:0]};
                    end
                    3'd2: begin
                        mem_we    = 4'b0011;
                        mem_wdata = {16'h0, b_reg[0], mem_rdata[7:0]};
                    end
                    default: begin
                        mem_we    = 4'b0001;
                        mem_wdata = {24'h0, mem_rdata[7:0]};
                    end
                endcase
                offset_next = offset_reg + {13'h0, chunk};
                remain_next = remain_reg - {13'h0, chunk};
                if (remain_reg == {13'h0, chunk}) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    state_next = READ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_dma_engine.sv
// Self-checking bench for mem_dma_engine: byte-addressed RAM model plus a transfer-level
// reference that expands each accepted start into its expected per-cycle port activity.
module tb_mem_dma_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = 32'h0;
    logic [31:0] dst_addr = 32'h0;
    logic [15:0] len = 16'h0;
    logic        busy, done, err;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_bus_col = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        wlog[$];
    exp_t        cur;
    logic        err_model = 1'b0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    logic [7:0]  ram [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] rnd;

    mem_dma_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .err(err), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_bus_col(mem_bus_col)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd_ram(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        ram[a] = v;
        ref_mem[a] = v;
    endtask

    // RAM port B: byte reads with one-cycle latency, big-endian multi-byte writes.
    always @(posedge clk) begin
        rnd = $urandom();
        case (mem_we)
            4'b0000: mem_rdata <= {rnd[31:8], rd_ram(mem_addr)};
            4'b0001: ram[mem_addr] = mem_wdata[7:0];
            4'b0011: begin
                ram[mem_addr]         = mem_wdata[15:8];
                ram[mem_addr + 32'd1] = mem_wdata[7:0];
            end
            4'b1111: begin
                ram[mem_addr]         = mem_wdata[31:24];
                ram[mem_addr + 32'd1] = mem_wdata[23:16];
                ram[mem_addr + 32'd2] = mem_wdata[15:8];
                ram[mem_addr + 32'd3] = mem_wdata[7:0];
            end
            default: ;
        endcase
    end

    // Expand one accepted transfer into the exact cycle sequence the engine must produce.
    task automatic gen(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        exp_t e;
        int   off = 0;
        int   rem = int'(n);
        while (rem > 0) begin
            int c = (rem >= 4) ? 4 : ((rem >= 2) ? 2 : 1);
            logic [31:0] w = 32'h0;
            for (int k = 0; k < c; k++) begin
                e = '0;
                e.busy = 1'b1;
                e.addr = s + 32'(off) + 32'(k);
                exp_q.push_back(e);
                w = (w << 8) | {24'h0, rd_ref(s + 32'(off) + 32'(k))};
            end
            e = '0;
            e.busy  = 1'b1;
            e.we    = (c == 4) ? 4'b1111 : ((c == 2) ? 4'b0011 : 4'b0001);
            e.addr  = d + 32'(off);
            e.wdata = w;
            exp_q.push_back(e);
            for (int k = 0; k < c; k++)
                ref_mem[d + 32'(off) + 32'(k)] = 8'(w >> (8 * (c - 1 - k)));
            off += c;
            rem -= c;
        end
        e = '0;
        e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    // Cycle-by-cycle comparison against the reference sequence.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            err_model = 1'b0;
            ref_mem = ram;
            cur = '0;
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = '0;
        end
        chk("busy", 32'(busy), 32'(cur.busy));
        chk("done", 32'(done), 32'(cur.done));
        chk("mem_we", 32'(mem_we), 32'(cur.we));
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_wdata", mem_wdata, cur.wdata);
        chk("err", 32'(err), 32'(err_model));
        if (rst_n) begin
            if (mem_bus_col && (cur.busy || cur.done)) err_model = 1'b1;
            if (start && !cur.busy) begin
                err_model = 1'b0;
                $display("start src=%h dst=%h len=%0d", src_addr, dst_addr, len);
                gen(src_addr, dst_addr, len);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we != 4'b0000) begin
                wlog.push_back('{busy: busy, done: done, we: mem_we, addr: mem_addr, wdata: mem_wdata});
                $display("write we=%b addr=%h data=%h", mem_we, mem_addr, mem_wdata);
            end
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(posedge clk); #1;
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        logic found = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        #1;
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // len=4 copy with literal per-cycle expectations.
        poke(32'h10, 8'h11); poke(32'h11, 8'h22); poke(32'h12, 8'h33); poke(32'h13, 8'h44);
        do_start(32'h10, 32'h100, 16'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("c4_read_we", 32'(mem_we), 32'd0);
            chk("c4_read_addr", mem_addr, 32'h10 + 32'(i));
        end
        @(negedge clk);
        chk("c4_write_we", 32'(mem_we), 32'hF);
        chk("c4_write_addr", mem_addr, 32'h100);
        chk("c4_write_data", mem_wdata, 32'h11223344);
        @(negedge clk);
        chk("c4_done", 32'(done), 32'd1);
        chk("c4_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("c4_ram", {rd_ram(32'h100), rd_ram(32'h101), rd_ram(32'h102), rd_ram(32'h103)}, 32'h11223344);

        // len=7 copy: 4+2+1 chunks.
        for (int i = 0; i < 7; i++) poke(32'h20 + 32'(i), 8'(i + 1));
        wlog.delete(); busy_cnt = 0;
        do_start(32'h20, 32'h200, 16'd7);
        wait_done("c7_done", 50);
        chk("c7_nwrites", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            chk("c7_w0", {28'h0, wlog[0].we} ^ wlog[0].addr ^ 32'h0, 32'hF ^ 32'h200);
            chk("c7_w0_data", wlog[0].wdata, 32'h01020304);
            chk("c7_w1_we", 32'(wlog[1].we), 32'h3);
            chk("c7_w1_addr", wlog[1].addr, 32'h204);
            chk("c7_w1_data", wlog[1].wdata, 32'h00000506);
            chk("c7_w2_we", 32'(wlog[2].we), 32'h1);
            chk("c7_w2_addr", wlog[2].addr, 32'h206);
            chk("c7_w2_data", wlog[2].wdata, 32'h00000007);
        end
        chk("c7_busy_cycles", 32'(busy_cnt), 32'd10);

        // len=0: immediate done, no busy, no write.
        wlog.delete(); busy_cnt = 0;
        do_start(32'h30, 32'h300, 16'd0);
        @(negedge clk);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        chk("len0_writes", 32'(wlog.size()), 32'd0);
        chk("len0_busy_cycles", 32'(busy_cnt), 32'd0);

        // Collision mid-transfer: completes, err sticky until next start.
        for (int i = 0; i < 6; i++) poke(32'h500 + 32'(i), 8'h60 + 8'(i));
        do_start(32'h500, 32'h600, 16'd6);
        @(posedge clk); #1;
        @(posedge clk); #1 mem_bus_col = 1'b1;
        @(posedge clk); #1 mem_bus_col = 1'b0;
        wait_done("col_done", 50);
        chk("col_err_at_done", 32'(err), 32'd1);
        chk("col_ram", {rd_ram(32'h602), rd_ram(32'h603), rd_ram(32'h604), rd_ram(32'h605)}, 32'h62636465);
        do_start(32'h500, 32'h700, 16'd2);
        @(negedge clk);
        chk("col_err_cleared", 32'(err), 32'd0);
        wait_done("col2_done", 50);

        // Reset in cycle 3 of a len=8 copy.
        for (int i = 0; i < 8; i++) poke(32'h800 + 32'(i), 8'hA0 + 8'(i));
        done_cnt = 0; wlog.delete();
        do_start(32'h800, 32'h900, 16'd8);
        @(posedge clk); #1;
        @(posedge clk); #2 rst_n = 1'b0;
        #1 chk_zero_outputs("midrst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        chk("midrst_no_write", 32'(wlog.size()), 32'd0);
        do_start(32'h800, 32'h900, 16'd8);
        wait_done("midrst_restart_done", 50);
        @(negedge clk);
        chk("midrst_ram", {rd_ram(32'h904), rd_ram(32'h905), rd_ram(32'h906), rd_ram(32'h907)}, 32'hA4A5A6A7);

        // Second start while busy is ignored.
        for (int i = 0; i < 5; i++) poke(32'hA00 + 32'(i), 8'h50 + 8'(i));
        done_cnt = 0; wlog.delete();
        do_start(32'hA00, 32'hB00, 16'd5);
        @(posedge clk); #1;
        src_addr = 32'hC00; dst_addr = 32'hD00; len = 16'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("sib_done", 50);
        repeat (4) @(negedge clk);
        chk("sib_one_done", 32'(done_cnt), 32'd1);
        chk("sib_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() > 0) chk("sib_first_addr", wlog[0].addr, 32'hB00);

        // Randomized transfers with collisions and ignored starts, incl. address wrap.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] s, d;
            logic [15:0] n;
            logic        found;
            s = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                            : 32'($urandom_range(0, 4095));
            d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 + 32'($urandom_range(0, 11))
                                            : 32'($urandom_range(0, 4095));
            n = 16'($urandom_range(0, 20));
            for (int i = 0; i < int'(n); i++) poke(s + 32'(i), 8'($urandom()));
            do_start(s, d, n);
            found = 1'b0;
            for (int cyc = 0; cyc < 200; cyc++) begin
                if (done) begin
                    found = 1'b1;
                    break;
                end
                @(posedge clk); #1;
                mem_bus_col = ($urandom_range(0, 9) == 0);
                if (busy && ($urandom_range(0, 7) == 0)) begin
                    start = 1'b1;
                    src_addr = $urandom(); dst_addr = $urandom(); len = 16'($urandom_range(1, 9));
                end else begin
                    start = 1'b0;
                end
            end
            start = 1'b0;
            mem_bus_col = 1'b0;
            chk("rand_done_seen", 32'(found), 32'd1);
        end

        repeat (4) @(negedge clk);
        chk("model_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_dma_engine.md
MEM_DMA_ENGINE -- requirements
Module: mem_dma_engine

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  in  1  transfer request, sampled only in IDLE.
REQ-004 SHALL have ports: src_addr  in  32 and dst_addr  in  32  byte addresses, latched on accepted start.
REQ-005 SHALL have port: len  in  16  byte count, latched on accepted start.
REQ-006 SHALL have ports: busy  out  1  transfer in progress; done  out  1  one-cycle completion pulse; err  out  1  sticky collision flag.
REQ-007 SHALL have ports: mem_we  out  4, mem_addr  out  32, mem_wdata  out  32  drive the RAM's port B write-enable, address and write data.
REQ-008 SHALL have ports: mem_rdata  in  32 and mem_bus_col  in  1  from RAM port B and the RAM collision flag.

Function
REQ-009 SHALL follow the port-B protocol: mem_we 4'b0000 = byte read, valid on mem_rdata[7:0] the next cycle, held until the next read; 4'b0001 = byte write of wdata[7:0]; 4'b0011 = big-endian halfword write, wdata[15:8]@addr, [7:0]@addr+1; 4'b1111 = big-endian word write, wdata[31:24]@addr .. [7:0]@addr+3.
REQ-010 SHALL implement states IDLE, READ, WRITE.
REQ-011 SHALL accept start only in IDLE; start asserted while busy SHALL be ignored.
REQ-012 SHALL, on accepted start with len=0, pulse done the next cycle, keep busy low and issue no write.
REQ-013 SHALL, on accepted start with len>0, latch the parameters, clear err, set busy the next cycle and enter READ.
REQ-014 SHALL select chunk size c at each chunk start: 4 if remaining>=4, else 2 if remaining>=2, else 1.
REQ-015 SHALL spend c consecutive READ cycles with mem_we=0000 and mem_addr=src+offset+k (k=0..c-1).
REQ-016 SHALL capture mem_rdata[7:0] as byte k-1 in READ cycle k (k>=1).
REQ-017 SHALL spend one WRITE cycle with mem_addr=dst+offset and mem_we=1111/0011/0001 for c=4/2/1.
REQ-018 SHALL, in WRITE, use mem_rdata[7:0] combinationally as the last byte of the chunk.
REQ-019 SHALL, in WRITE, drive mem_wdata = {b0,b1,b2,rdata} for c=4; {16'h0,b0,rdata} for c=2; {24'h0,rdata} for c=1.
REQ-020 SHALL, after WRITE, advance offset by c and return to READ if remaining>0.
REQ-021 SHALL, when remaining reaches 0, go to IDLE, drop busy and pulse done for one cycle.
REQ-022 SHALL take c+1 cycles per chunk; total busy cycles = len + number of chunks.
REQ-023 SHALL compute addresses modulo 2^32 and perform no range or alignment check.
REQ-024 SHALL drive mem_we=0000, mem_addr=0, mem_wdata=0 in IDLE.
REQ-025 SHALL set err when mem_bus_col=1 while busy or in the done cycle; err SHALL hold until the next accepted start and SHALL NOT abort the transfer.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state=IDLE and busy=done=err=0, mem_we=0000, mem_addr=0, mem_wdata=0, and all internal counters and byte registers to 0.
REQ-027 SHALL, on reset asserted mid-transfer, abandon the transfer with no done pulse and no further writes.

Verification
REQ-028 SHALL cover len=4 copy: src=0x10, dst=0x100, RAM[0x10..0x13]=11,22,33,44 -> reads 0x10..0x13 in cycles 1-4; cycle 5 we=1111 addr=0x100 wdata=0x11223344; cycle 6 done=1, busy=0.
REQ-029 SHALL cover len=7 copy: src=0x20 holding 01..07, dst=0x200 -> writes 1111@0x200 0x01020304, 0011@0x204 0x00000506, 0001@0x206 0x00000007; busy 10 cycles.
REQ-030 SHALL cover len=0: start -> done pulse next cycle, busy stays 0, no write strobe.
REQ-031 SHALL cover collision: mem_bus_col=1 for one cycle mid-transfer -> transfer completes unchanged, err=1 at done, err=0 after next start.
REQ-032 SHALL cover reset mid-transfer: rst_n low in cycle 3 of a len=8 copy -> all outputs 0 at once, no done; a new start after release completes normally.
REQ-033 SHALL cover start during busy: second start pulse in cycle 2 -> ignored, original parameters used, exactly one done.
